inst_loader: RTL and testbench

- Boot-time program loader upstream of the instruction RAM write port.
- Accepts a little-endian byte stream (valid/ready) carrying a 32-bit word-count header followed by instruction words.
- Assembles the bytes into 32-bit words and drives is_write/im_addr/im_inst to the instruction RAM.
- Holds the core in reset (core_rst_n low) until the load completes.

---
 rtl/inst_loader.sv | 166 ++++++++++++++++
 tb/tb_inst_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Boot-time instruction loader.
// Takes a little-endian byte stream (valid/ready): a 32-bit word-count header
// followed by that many 32-bit instruction words. Each assembled word is
// written to the instruction RAM with a one-cycle is_write strobe. The core
// is held in reset (core_rst_n low) until the load completes successfully.
// Optional feature: define INST_LOADER_CHECKSUM_EN to require a trailing
// XOR-of-data-bytes checksum byte before the load is declared done.
module inst_loader #(
   parameter int             w         = 32,
   parameter int             DEPTH     = 2048,
   parameter logic [w-1:0]   BASE_ADDR = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic         rx_ready,
   output logic         is_write,
   output logic [w-1:0] im_addr,
   output logic [w-1:0] im_inst,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic         core_rst_n
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_WR,
      ST_CHK,
      ST_DONE,
      ST_ERR
   } state_t;

   // State entered once the last word is written (or after an empty header).
`ifdef INST_LOADER_CHECKSUM_EN
   localparam state_t ST_LAST = ST_CHK;
`else
   localparam state_t ST_LAST = ST_DONE;
`endif

   state_t        state, state_nxt;
   logic [1:0]    byte_cnt;
   logic [31:0]   word;
   logic [31:0]   count;
   logic [31:0]   k;
   logic [31:0]   assembled;
   logic [w-1:0]  addr_nxt;
   logic          xfer;
   logic          last_byte;
   logic          start_ok;
`ifdef INST_LOADER_CHECKSUM_EN
   logic [7:0]    csum;
`endif

   // New bytes enter at the top so the first byte of a group ends up in [7:0].
   assign assembled = {rx_data, word[31:8]};
   assign xfer      = rx_valid && rx_ready;
   assign last_byte = (byte_cnt == 2'd3);
   assign start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
   assign addr_nxt  = BASE_ADDR + w'({k[29:0], 2'b00});

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      // NOTE: default first, so no path through the case leaves state_nxt
      // unassigned and infers a latch.
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR:
            if (start) state_nxt = ST_LEN;
         ST_LEN:
            if (xfer && last_byte) begin
               if (assembled == 32'd0)               state_nxt = ST_LAST;
               else if (assembled > 32'(DEPTH))      state_nxt = ST_ERR;
               else                                  state_nxt = ST_DATA;
            end
         ST_DATA:
            if (xfer && last_byte) state_nxt = ST_WR;
         ST_WR:
            state_nxt = (k + 32'd1 == count) ? ST_LAST : ST_DATA;
`ifdef INST_LOADER_CHECKSUM_EN
         ST_CHK:
            if (xfer) state_nxt = (rx_data == csum) ? ST_DONE : ST_ERR;
`endif
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      rx_ready   = 1'b0;
      is_write   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      core_rst_n = 1'b0;
      case (state)
         ST_LEN, ST_DATA, ST_CHK: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
         end
         ST_WR: begin
            is_write = 1'b1;
            busy     = 1'b1;
         end
         ST_DONE: begin
            done       = 1'b1;
            core_rst_n = 1'b1;
         end
         ST_ERR:  error = 1'b1;
         default: ;
      endcase
   end

   // Byte assembly, header capture, word index and write-port registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt <= 2'd0;
         word     <= 32'd0;
         count    <= 32'd0;
         k        <= 32'd0;
         im_addr  <= '0;
         im_inst  <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
         csum     <= 8'd0;
`endif
      end else if (start_ok) begin
         byte_cnt <= 2'd0;
         word     <= 32'd0;
         count    <= 32'd0;
         k        <= 32'd0;
`ifdef INST_LOADER_CHECKSUM_EN
         csum     <= 8'd0;
`endif
      end else begin
         if (xfer) begin
            word     <= assembled;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == ST_LEN && last_byte) count <= assembled;
            if (state == ST_DATA) begin
`ifdef INST_LOADER_CHECKSUM_EN
               csum <= csum ^ rx_data;
`endif
               if (last_byte) begin
                  im_inst <= w'(assembled);
                  im_addr <= addr_nxt;
               end
            end
         end
         if (state == ST_WR) k <= k + 32'd1;
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed loads from the test plan plus
// randomized loads with random valid gaps, checked against a word-list model.
module tb_inst_loader;

   localparam int          W     = 32;
   localparam int          DEPTH = 2048;
   localparam logic [31:0] BASE  = 32'h100;

   typedef logic [31:0] word_q_t[$];
   typedef logic [7:0]  byte_q_t[$];

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    rx_data = 8'd0;
   logic          rx_valid = 1'b0;
   logic          rx_ready, is_write, busy, done, error, core_rst_n;
   logic [W-1:0]  im_addr, im_inst;

   int vectors = 0;
   int miscompares = 0;
   logic [63:0] wr_q[$];

   inst_loader #(.w(W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .is_write(is_write), .im_addr(im_addr), .im_inst(im_inst),
      .busy(busy), .done(done), .error(error), .core_rst_n(core_rst_n)
   );

   always #5 clk = ~clk;

   // Record every RAM write as {addr, inst}.
   always @(negedge clk) if (is_write) wr_q.push_back({im_addr, im_inst});

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Drive a byte stream; data_end marks the end of instruction bytes so the
   // bench knows which transfers must be followed by a write pulse.
   task automatic send_bytes(input byte_q_t q, input int data_end, input bit gaps, input int stall_at);
      int i = 0;
      int cyc = 0;
      int lat = 0;
      int nwr;
      bit stalled = 1'b0;
      while (i < q.size() && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (lat == 1) begin check("wr_pulse", is_write, 1); lat = 2; end
         else if (lat == 2) begin check("wr_single", is_write, 0); lat = 0; end
         if (i == stall_at && !stalled) begin
            stalled  = 1'b1;
            nwr      = wr_q.size();
            rx_valid = 1'b0;
            start    = 1'b1;              // must be ignored while busy
            @(negedge clk) start = 1'b0;
            repeat (9) @(negedge clk);
            check("stall_nowr", wr_q.size(), nwr);
            check("stall_busy", busy, 1);
         end
         if (gaps && $urandom_range(0, 3) == 0) begin
            rx_valid = 1'b0;
         end else begin
            rx_valid = 1'b1;
            rx_data  = q[i];
            if (rx_ready) begin
               if (i >= 4 && i < data_end && (i % 4) == 3) lat = 1;
               i++;
            end
         end
      end
      if (i < q.size()) check("send_timeout", i, q.size());
      @(negedge clk) rx_valid = 1'b0;
      if (lat == 1) check("wr_pulse", is_write, 1);
   endtask

   task automatic wait_end(input int exp_lat);
      int c = 0;
      while (!(done || error) && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("end_latency", c, exp_lat);
   endtask

   // Full load: build the stream, run it, compare against the word-list model.
   task automatic run_load(input logic [31:0] n, input word_q_t words, input bit gaps, input int stall_at);
      byte_q_t q;
      logic [7:0] x = 8'd0;
      bit ok = (n <= DEPTH);
      int data_end;
      int nexp;
      int exp_lat;
      for (int b = 0; b < 4; b++) q.push_back(n[8*b +: 8]);
      if (ok) begin
         foreach (words[j]) begin
            for (int b = 0; b < 4; b++) begin
               q.push_back(words[j][8*b +: 8]);
               x ^= words[j][8*b +: 8];
            end
         end
      end
      data_end = q.size();
`ifdef INST_LOADER_CHECKSUM_EN
      if (ok) q.push_back(x);
      exp_lat = 0;
`else
      exp_lat = (ok && n != 0) ? 1 : 0;
`endif
      pulse_start();
      check("start_busy", busy, 1);
      check("start_core_rst", core_rst_n, 0);
      check("start_done", done, 0);
      check("start_error", error, 0);
      wr_q.delete();
      send_bytes(q, data_end, gaps, stall_at);
      wait_end(exp_lat);
      nexp = ok ? int'(n) : 0;
      check("n_writes", wr_q.size(), nexp);
      for (int j = 0; j < nexp && j < wr_q.size(); j++)
         check("write", wr_q[j], {BASE + 32'(4 * j), words[j]});
      check("end_done", done, ok);
      check("end_error", error, !ok);
      check("end_core_rst", core_rst_n, ok);
      check("end_ready", rx_ready, 0);
      check("end_busy", busy, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, rx_ready, 0);
      check({tag, "_wr"}, is_write, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_core_rst"}, core_rst_n, 0);
      check({tag, "_addr"}, im_addr, 0);
      check({tag, "_inst"}, im_inst, 0);
   endtask

   initial begin
      word_q_t wq;
      byte_q_t bq;

      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;

      // Two-word program from the test plan.
      wq = '{32'h00100513, 32'h00200593};
      run_load(32'd2, wq, 1'b0, -1);

      // Single word.
      wq = '{32'hDEADBEEF};
      run_load(32'd1, wq, 1'b0, -1);

      // Header above DEPTH, then recovery.
      wq = '{};
      run_load(32'd2049, wq, 1'b0, -1);
      wq = '{32'hCAFEF00D};
      run_load(32'd1, wq, 1'b0, -1);

      // Stall between bytes 2 and 3 of the first word, with an ignored start.
      wq = '{32'h12345678, 32'h9ABCDEF0};
      run_load(32'd2, wq, 1'b0, 6);

      // Empty program.
      wq = '{};
      run_load(32'd0, wq, 1'b0, -1);

      // Reset after 6 data bytes of a 4-word load.
      bq = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      pulse_start();
      send_bytes(bq, bq.size(), 1'b0, -1);
      @(negedge clk) rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk) rst_n = 1'b1;
      wq = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'h01234567};
      run_load(32'd3, wq, 1'b1, -1);

      // Randomized loads with random valid gaps.
      for (int t = 0; t < 8; t++) begin
         int n = $urandom_range(1, 6);
         wq = '{};
         for (int j = 0; j < n; j++) wq.push_back($urandom);
         run_load(32'(n), wq, 1'b1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
